// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and sender-side bus of the UART transmit arbiter
//   i_req_valid  per-requester byte valid, held until its o_req_ready pulse
//   i_req_data   requester k byte at [8k+7:8k]
//   o_req_ready  one-hot accept pulse
//   o_tx_dv      launch pulse to the sender's i_tx_dv
//   o_tx_data    byte to the sender's i_tx_data
//   o_grant_id   index of the last granted requester
//   o_busy       low only while the arbiter is idle
// Directions are named from the arbiter's point of view: slave = arbiter, master = requesters/bench.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic                 o_tx_dv;
  logic [7:0]           o_tx_data;
  logic [IW-1:0]        o_grant_id;
  logic                 o_busy;
  modport slave (input i_req_valid, i_req_data, output o_req_ready, o_tx_dv, o_tx_data, o_grant_id, o_busy);
  modport master (output i_req_valid, i_req_data, input o_req_ready, o_tx_dv, o_tx_data, o_grant_id, o_busy);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART sender among NUM_REQ byte producers
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      uart_tx_arbiter_if.slave (requester handshake in, sender launch/data out)
// Optional feature macro UART_ARB_PRIO0_EN: requester 0 wins whenever valid, the rest stay round-robin.
// The sender has no done output, so every frame is timed here for FRAME_CLKS clocks.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 87,
  parameter int NUM_REQ      = 4,
  parameter int FRAME_BITS   = 10,
  parameter int GUARD_CLKS   = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS + GUARD_CLKS;
  localparam int CW = $clog2(FRAME_CLKS);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CLKS - 1);
  typedef enum logic [1:0] {HOLD, IDLE, WAIT} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0] w_cand;
  logic [IW:0]        w_sum;
  logic [IW:0]        w_idx;
  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_next_ptr;
  // First candidate at or after r_rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
`ifdef UART_ARB_PRIO0_EN
    w_cand  = bus.i_req_valid & ~NUM_REQ'(1);
`else
    w_cand  = bus.i_req_valid;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(i);
      w_idx = (w_sum >= (IW+1)'(NUM_REQ)) ? w_sum - (IW+1)'(NUM_REQ) : w_sum;
      if (!w_found && w_cand[w_idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IW-1:0];
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (bus.i_req_valid[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
    w_next_ptr = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end
  // HOLD after reset covers a frame the un-reset sender may still be shifting out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= HOLD;
      r_cnt           <= '0;
      r_rr_ptr        <= '0;
      bus.o_tx_dv     <= 1'b0;
      bus.o_tx_data   <= '0;
      bus.o_req_ready <= '0;
      bus.o_grant_id  <= '0;
      bus.o_busy      <= 1'b1;
    end else begin
      bus.o_tx_dv     <= 1'b0;
      bus.o_req_ready <= '0;
      case (r_state)
        HOLD, WAIT: begin
          if (r_cnt == LAST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            bus.o_busy <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (w_found) begin
            bus.o_tx_data   <= bus.i_req_data[{w_win, 3'b000} +: 8];
            bus.o_tx_dv     <= 1'b1;
            bus.o_req_ready <= NUM_REQ'(1) << w_win;
            bus.o_grant_id  <= w_win;
            bus.o_busy      <= 1'b1;
            r_cnt           <= '0;
            r_state         <= WAIT;
`ifdef UART_ARB_PRIO0_EN
            if (w_win != '0) r_rr_ptr <= w_next_ptr;
`else
            r_rr_ptr <= w_next_ptr;
`endif
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (default parameters, 873-clock frame spacing)
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int GAP = 873;
  typedef struct {int id; int d; int gap;} exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int errs = 0;
  int cyc = 0;
  int last_ref = 0;
  int dv_cnt = 0;
  exp_t q[$];
  exp_t e;
  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  uart_tx_arbiter #(.CLKS_PER_BIT(87), .NUM_REQ(NUM_REQ), .FRAME_BITS(10), .GUARD_CLKS(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) last_ref = cyc;
    else begin
      if (bus.o_req_ready != '0 && !bus.o_tx_dv) begin
        tests++;
        errs++;
        $display("FAIL stray_ready: ready=%b without dv at cycle %0d", bus.o_req_ready, cyc);
      end
      if (bus.o_tx_dv) begin
        dv_cnt++;
        if (q.size() == 0) begin
          tests++;
          errs++;
          $display("FAIL unexpected_dv: id=%0d data=%02h, no grant expected at cycle %0d", bus.o_grant_id, bus.o_tx_data, cyc);
        end else begin
          e = q.pop_front();
          chk("grant_id", int'(bus.o_grant_id), e.id);
          chk("tx_data", int'(bus.o_tx_data), e.d);
          chk("req_ready", int'(bus.o_req_ready), 1 << e.id);
          chk("busy_in_frame", int'(bus.o_busy), 1);
          if (e.gap != 0) chk("dv_gap", cyc - last_ref, e.gap);
        end
        last_ref = cyc;
      end
    end
  end
  task automatic set_req(input int k, input logic [7:0] d);
    bus.i_req_valid[k] = 1'b1;
    bus.i_req_data[8*k +: 8] = d;
  endtask
  task automatic exp_push(input int k, input int d, input int gap);
    q.push_back('{k, d, gap});
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tx_dv", int'(bus.o_tx_dv), 0);
    chk("rst_tx_data", int'(bus.o_tx_data), 0);
    chk("rst_req_ready", int'(bus.o_req_ready), 0);
    chk("rst_grant_id", int'(bus.o_grant_id), 0);
    chk("rst_busy", int'(bus.o_busy), 1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask
  // Requesters drop valid on their ready pulse unless listed in keep.
  task automatic run_dvs(input int n, input logic [NUM_REQ-1:0] keep);
    int seen = 0;
    int t = 0;
    while (seen < n && t < 1000 * n + 1000) begin
      @(negedge clk);
      t++;
      if (bus.o_req_ready != '0) begin
        seen++;
        bus.i_req_valid = bus.i_req_valid & ~(bus.o_req_ready & ~keep);
      end
    end
    chk("grants_seen", seen, n);
  endtask
  initial begin
    int n0;
    rst_n = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_data = '0;
    set_req(2, 8'hA5);
    exp_push(2, 'hA5, GAP);
    do_reset();
    run_dvs(1, '0);
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 8'(8'h10 + 8'h11 * k));
`ifdef UART_ARB_PRIO0_EN
    for (int i = 0; i < 5; i++) exp_push(0, 'h10, GAP);
`else
    exp_push(0, 'h10, GAP); exp_push(1, 'h21, GAP); exp_push(2, 'h32, GAP);
    exp_push(3, 'h43, GAP); exp_push(0, 'h10, GAP);
`endif
    do_reset();
    run_dvs(5, 4'hF);
    bus.i_req_valid = '0;
    repeat (900) @(negedge clk);
    set_req(3, 8'hC3);
    exp_push(3, 'hC3, 0);
    run_dvs(1, '0);
    set_req(1, 8'h5A);
    set_req(3, 8'hC3);
    exp_push(1, 'h5A, GAP);
    exp_push(3, 'hC3, GAP);
    run_dvs(2, '0);
    repeat (900) @(negedge clk);
    set_req(2, 8'h77);
    exp_push(2, 'h77, 0);
    n0 = dv_cnt;
    run_dvs(1, 4'b0100);
    @(negedge clk);
    bus.i_req_valid[2] = 1'b0;
    repeat (1000) @(negedge clk);
    chk("single_grant_extra_valid", dv_cnt - n0, 1);
    set_req(1, 8'h11);
    exp_push(1, 'h11, 0);
    run_dvs(1, '0);
    repeat (400) @(negedge clk);
    set_req(0, 8'h01);
    set_req(3, 8'h33);
    exp_push(0, 'h01, GAP);
    exp_push(3, 'h33, GAP);
    do_reset();
    run_dvs(2, '0);
    repeat (900) @(negedge clk);
    set_req(0, 8'hE0);
    set_req(1, 8'hE1);
`ifdef UART_ARB_PRIO0_EN
    exp_push(0, 'hE0, 0); exp_push(0, 'hE0, GAP); exp_push(0, 'hE0, GAP);
`else
    exp_push(0, 'hE0, 0); exp_push(1, 'hE1, GAP); exp_push(0, 'hE0, GAP);
`endif
    run_dvs(3, 4'b0011);
    bus.i_req_valid[0] = 1'b0;
    exp_push(1, 'hE1, GAP);
    run_dvs(1, '0);
    repeat (900) @(negedge clk);
    chk("busy_idle", int'(bus.o_busy), 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_sender (8N1, CLKS_PER_BIT clocks per bit) among NUM_REQ byte producers.
- Round-robin arbitration; drives the sender's i_tx_dv and i_tx_data.
- Times each frame internally, because the sender has no done output, so a new byte is never launched into a busy sender.
- Sits between requester logic and the UART_sender; the sender's o_tx goes to the line unchanged.

Parameters:
- CLKS_PER_BIT, 87, clocks per UART bit; must match the sender instance.
- NUM_REQ, 4, number of requesters, 2..8.
- FRAME_BITS, 10, bits per frame (start + 8 data + stop).
- GUARD_CLKS, 2, extra idle clocks after each frame so the sender returns to idle.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester byte-valid; held until matching o_req_ready.
- i_req_data  input  8*NUM_REQ  requester k byte at [8k+7:8k]; stable while valid.
- o_req_ready  output  NUM_REQ  one-hot, 1-cycle pulse: byte from requester k accepted.
- o_tx_dv  output  1  1-cycle launch pulse to sender i_tx_dv.
- o_tx_data  output  8  byte to sender i_tx_data; registered, held until next grant.
- o_grant_id  output  $clog2(NUM_REQ)  index of last granted requester.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
- FRAME_CLKS = CLKS_PER_BIT*FRAME_BITS + GUARD_CLKS (default 872).
- Counter width is $clog2(FRAME_CLKS).
- States:
  - HOLD: post-reset drain.
  - IDLE.
  - WAIT: frame in flight.
- Reset (async, i_rst_n=0):
  - state=HOLD, counter=0, rr_ptr=0.
  - All outputs 0: o_tx_dv, o_tx_data, o_req_ready, o_grant_id, o_busy=1 (HOLD).
- HOLD:
  - Counter increments each clock.
  - At counter==FRAME_CLKS-1: counter clears and state goes to IDLE.
  - Lets any frame the un-reset sender was sending complete. Applies to reset mid-frame too.
- IDLE with no valid: stay, outputs idle.
- IDLE, any i_req_valid=1: winner k is the first set bit scanning from rr_ptr upward, wrapping at NUM_REQ-1 to 0. On that edge:
  - o_tx_data <= data k, o_tx_dv <= 1, o_req_ready <= 1<<k, o_grant_id <= k.
  - rr_ptr <= (k+1) mod NUM_REQ, counter <= 0, state <= WAIT.
- o_tx_dv and o_req_ready are high exactly one cycle.
- Latency: valid sampled at edge n produces dv/ready high during cycle n+1.
- WAIT:
  - Counter increments; all valids are ignored, so no second grant to a requester still holding valid in the ready cycle.
  - At counter==FRAME_CLKS-1: state <= IDLE.
- Continuous requests: dv pulses spaced FRAME_CLKS+1 clocks apart (873 at defaults).
- A requester dropping valid before grant: no grant, no state change.
- Simultaneous valids: exactly one grant per frame; the others keep waiting.
- rr_ptr wrap: grant to NUM_REQ-1 sets rr_ptr=0.
- o_busy=0 only in IDLE.

Optional Feature:
- Macro: UART_ARB_PRIO0_EN
- Defined: requester 0 is high priority and wins whenever valid in IDLE, regardless of rr_ptr. A grant to 0 leaves rr_ptr unchanged. Requesters 1..NUM_REQ-1 stay round-robin among themselves.
- Undefined: pure round-robin over all requesters, as described above.

Test Plan:
- Reset then hold valid[2]=1, data 0xA5 -> no dv for the first 872 clocks (HOLD). Then one dv pulse with o_tx_data=0xA5, ready=4'b0100, grant_id=2. A receiver on o_tx reads 0xA5.
- All four valid continuously, data 0x10,0x21,0x32,0x43 -> grants in order 0,1,2,3,0, dv pulses exactly 873 clocks apart, receiver bytes in the same order.
- valid[3] only, then valid[1] and valid[3] together -> after grant 3 (rr_ptr wraps to 0), the next grant goes to 1, then 3.
- Requester keeps valid high one extra cycle after ready -> no second grant during WAIT; exactly one byte received.
- Assert i_rst_n=0 for 3 clocks mid-frame (counter ~400) -> outputs 0 immediately, HOLD for 872 clocks, no dv during HOLD, next grant goes to requester 0 first.
- With UART_ARB_PRIO0_EN defined: valid[0] and valid[1] held -> every grant goes to 0. Drop valid[0] -> grant 1. Without the macro -> alternating 0,1.
